// File: rtl/pc_fetch_unit.sv
// Sequential-PC instruction fetch: issues one imem request at a time from the
// architectural PC and hands each fetched word, paired with its PC, to decode.
module pc_fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_resp_valid,
    input  logic [31:0]       imem_resp_data,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [31:0]       inst_data,
    input  logic              inst_ready
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_run;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [ADDR_W-1:0] r_req_pc, w_req_pc_nxt;
    logic              r_discard, w_discard_nxt;
    logic              r_inst_valid, w_inst_valid_nxt;
    logic [ADDR_W-1:0] r_inst_pc, w_inst_pc_nxt;
    logic [31:0]       r_inst_data, w_inst_data_nxt;
    logic              w_req_valid;
    logic              w_req_fire;
    logic [ADDR_W-1:0] w_redirect_tgt;

    // r_run keeps the request line low until the first edge after reset release
    assign w_req_valid    = r_run && (r_state == ST_REQ) && !stall;
    assign w_req_fire     = w_req_valid && imem_req_ready;
    assign w_redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign inst_valid     = r_inst_valid;
    assign inst_pc        = r_inst_pc;
    assign inst_data      = r_inst_data;

    // Next-state and datapath selection; redirect overrides every other event
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_req_pc_nxt     = r_req_pc;
        w_discard_nxt    = r_discard;
        w_inst_valid_nxt = r_inst_valid;
        w_inst_pc_nxt    = r_inst_pc;
        w_inst_data_nxt  = r_inst_data;
        if (redirect_valid) begin
            w_pc_nxt         = w_redirect_tgt;
            w_inst_valid_nxt = 1'b0;
            case (r_state)
                ST_REQ: begin
                    // A request accepted this cycle still returns data that must be dropped
                    if (w_req_fire) begin
                        w_state_nxt   = ST_WAIT;
                        w_discard_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        w_state_nxt   = ST_REQ;
                        w_discard_nxt = 1'b0;
                    end else begin
                        w_state_nxt   = ST_WAIT;
                        w_discard_nxt = 1'b1;
                    end
                end
                ST_HOLD: begin
                    w_state_nxt = ST_REQ;
                end
                default: begin
                    w_state_nxt   = ST_REQ;
                    w_discard_nxt = 1'b0;
                end
            endcase
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (w_req_fire) begin
                        w_req_pc_nxt = r_pc;
                        w_pc_nxt     = r_pc + {{(ADDR_W-3){1'b0}}, 3'b100};
                        w_state_nxt  = ST_WAIT;
                    end else begin
                        w_state_nxt  = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid && r_discard) begin
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = ST_REQ;
                    end else if (imem_resp_valid) begin
                        w_inst_data_nxt  = imem_resp_data;
                        w_inst_pc_nxt    = r_req_pc;
                        w_inst_valid_nxt = 1'b1;
                        w_state_nxt      = ST_HOLD;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (inst_ready) begin
                        w_inst_valid_nxt = 1'b0;
                        w_state_nxt      = ST_REQ;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
                default: begin
                    w_state_nxt   = ST_REQ;
                    w_discard_nxt = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_REQ;
            r_run        <= 1'b0;
            r_pc         <= RESET_PC;
            r_req_pc     <= RESET_PC;
            r_discard    <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst_pc    <= '0;
            r_inst_data  <= 32'h0000_0000;
        end else begin
            r_state      <= w_state_nxt;
            r_run        <= 1'b1;
            r_pc         <= w_pc_nxt;
            r_req_pc     <= w_req_pc_nxt;
            r_discard    <= w_discard_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
            r_inst_data  <= w_inst_data_nxt;
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Consumer side of the sequential-PC path. Holds the architectural PC and issues instruction-memory read requests from it.
- Advances the PC by 4 on every accepted request and returns the fetched instruction, paired with its PC, to the decode stage over a valid/ready handshake.
- Accepts redirects (branch/jump/exception) at any time and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- ADDR_W, 32, PC/address width; instruction width is fixed at 32.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  inhibits issuing new imem requests while high.
- redirect_valid  in  1  one-cycle pulse: load redirect_pc, flush fetch.
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] are forced to 0.
- imem_req_valid  out  1  request is presented.
- imem_req_addr  out  ADDR_W  word-aligned request address (current PC).
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_resp_valid  in  1  read data is valid (at most one outstanding).
- imem_resp_data  in  32  instruction word.
- inst_valid  out  1  instruction output is valid.
- inst_pc  out  ADDR_W  PC of the output instruction.
- inst_data  out  32  output instruction.
- inst_ready  in  1  decode accepts the instruction.

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0:
  - pc = RESET_PC; state = REQ; discard = 0.
  - imem_req_valid = 0, inst_valid = 0, inst_pc = 0, inst_data = 0.
- First request: imem_req_valid rises in the first cycle after rst_n deasserts, with imem_req_addr = RESET_PC.
- FSM has three states: REQ, WAIT, HOLD.
- REQ:
  - imem_req_valid = !stall; imem_req_addr = pc.
  - On valid&&ready: req_pc <= pc, pc <= pc+4 (mod 2^ADDR_W; 32'hFFFF_FFFC wraps to 0), go to WAIT.
- WAIT:
  - imem_req_valid = 0.
  - On imem_resp_valid with discard=1: clear discard, go to REQ. No output is produced.
  - On imem_resp_valid with discard=0: inst_data <= resp_data, inst_pc <= req_pc, inst_valid <= 1, go to HOLD.
- HOLD:
  - inst_valid = 1; inst_pc and inst_data are held stable.
  - On inst_ready: inst_valid <= 0, go to REQ. The next request can issue in the following cycle.
- Latency: request accepted in cycle N; response arriving in cycle M gives inst_valid=1 in cycle M+1. Throughput is at most one instruction every 3 cycles; this is intentional and no pipelining is required.
- Request stability: once imem_req_valid=1 and ready=0, addr and valid hold until accepted. Exception: a redirect may change addr, and stall may drop valid.
- Redirect (redirect_valid=1) has highest priority over every other event in the same cycle:
  - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; inst_valid <= 0.
  - From REQ: a request handshaking in this same cycle is accepted by memory, so go to WAIT with discard=1 and leave pc = redirect target. Otherwise stay in REQ.
  - From WAIT: if imem_resp_valid arrives this same cycle, drop it and go to REQ. Otherwise stay in WAIT with discard <= 1.
  - From HOLD: go to REQ; the held instruction is lost even if inst_ready=1 in the same cycle.
- stall only gates issue in REQ. It does not block a response in WAIT or drain in HOLD, and it does not change pc.
- Back-to-back redirects: the last one wins. discard stays 1 while the single stale response is still outstanding.
- Unused corners:
  - imem_resp_valid in REQ/HOLD is a protocol violation; it is ignored.
  - inst_ready while inst_valid=0 has no effect.
- Reset asserted mid-operation returns to the reset state immediately. A memory response arriving after reset is a system-level hazard and is ignored in REQ.

Test Plan:
- Reset release, imem ready always, resp 1 cycle after accept, inst_ready=1 -> requests at 0x3000, 0x3004, 0x3008; inst_pc sequence matches, inst_data equals memory model words.
- inst_ready held 0 for 5 cycles in HOLD -> inst_valid, inst_pc=0x3000 and inst_data stay constant; no new imem request issued until the cycle after inst_ready=1.
- Redirect to 0x0000_4002 while in WAIT, stale resp arrives 2 cycles later -> stale data never appears on inst_*; next request addr = 0x4000; first inst_pc = 0x4000.
- Redirect in the same cycle as imem_resp_valid, and separately in the same cycle as inst_ready in HOLD -> in both cases no instruction is delivered and the next request addr = redirect target.
- stall=1 for 3 cycles in REQ with imem_req_ready=1 -> imem_req_valid=0 and pc unchanged; after stall drops, request addr is the pre-stall PC.
- Redirect to 0xFFFF_FFFC, then two fetches -> request addrs 0xFFFF_FFFC then 0x0000_0000 (wrap); assert rst_n=0 mid-WAIT -> outputs clear asynchronously and restart at RESET_PC.
